// File: rtl/a_plus_b_rr_scheduler.sv
// a_plus_b_rr_scheduler
// Shares one width-bit a+b adder among n_ch requester channels. A round-robin
// scheduler picks one operand pair per cycle. The sum is registered together
// with the id of the channel that produced it, in a single-entry output stage
// that uses a valid/ready handshake to the sink.
// Optional feature macro: ARB_STATS_EN adds the grant_cnt port. That port
// carries per-channel saturating 16-bit grant counters.

module a_plus_b_rr_scheduler #(
   parameter int width = 8,
   parameter int n_ch  = 4,
   localparam int id_w = $clog2(n_ch)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [n_ch-1:0]         req_valid,
   output logic [n_ch-1:0]         req_ready,
   input  logic [n_ch*width-1:0]   req_a,
   input  logic [n_ch*width-1:0]   req_b,
   output logic                    sum_valid,
   input  logic                    sum_ready,
   output logic [width-1:0]        sum_data,
   output logic [id_w-1:0]         sum_ch
`ifdef ARB_STATS_EN
   ,
   output logic [n_ch*16-1:0]      grant_cnt
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

   slot_state_t      state_q;
   logic             sum_valid_q;
   logic [width-1:0] sum_data_q;
   logic [id_w-1:0]  sum_ch_q;
   logic [id_w-1:0]  ptr_q;

   logic             slot_free;
   logic [n_ch-1:0]  hs;
   logic             xfer;
   logic [id_w-1:0]  win_id;
   logic [width-1:0] sum_d;
   logic [id_w-1:0]  ptr_d;

   // The slot can take a new result when it is empty, or when the sink is
   // draining the held result in this same cycle.
   always_comb begin
      slot_free = (state_q == EMPTY) || sum_ready;
   end

   // Channel i is ready when the slot is free and no channel ahead of it in
   // round-robin order (ptr, ptr+1, ... up to i-1) is valid. Channel i's own
   // valid is deliberately left out, so the result is never a combinational
   // loop back to that requester. Idle channels below the winner may also
   // see ready, but only the winner also has valid. The valid&ready
   // handshake is therefore always one-hot or zero.
   always_comb begin
      logic           blocked;
      logic           reached;
      int             j;
      logic [id_w-1:0] jIdx;
      req_ready = '0;
      blocked   = 1'b0;
      reached   = 1'b0;
      j         = 0;
      jIdx      = '0;
      for (int i = 0; i < n_ch; i++) begin
         blocked = 1'b0;
         reached = 1'b0;
         for (int k = 0; k < n_ch; k++) begin
            j = int'(ptr_q) + k;
            if (j >= n_ch) begin
               j = j - n_ch;
            end
            jIdx = j[id_w-1:0];
            if (j == i) begin
               reached = 1'b1;
            end
            if (!reached) begin
               blocked = blocked | req_valid[jIdx];
            end
         end
         req_ready[i] = slot_free & ~blocked;
      end
   end

   // Select the winning channel from the one-hot handshake. Compute its sum
   // with the carry dropped, and compute the pointer position just past it.
   always_comb begin
      hs     = req_valid & req_ready;
      xfer   = |hs;
      win_id = '0;
      sum_d  = '0;
      for (int i = 0; i < n_ch; i++) begin
         if (hs[i]) begin
            win_id = i[id_w-1:0];
            sum_d  = req_a[i*width +: width] + req_b[i*width +: width];
         end
      end
      if (win_id == id_w'(n_ch - 1)) begin
         ptr_d = '0;
      end else begin
         ptr_d = win_id + id_w'(1);
      end
   end

   // Output-stage FSM. It holds the registered result, its channel id and
   // the round-robin pointer. A drain and an accept in the same cycle keep
   // the stage FULL with the new result. A stalled result stays frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         sum_valid_q <= 1'b0;
         sum_data_q  <= '0;
         sum_ch_q    <= '0;
         ptr_q       <= '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (xfer) begin
                  state_q     <= FULL;
                  sum_valid_q <= 1'b1;
                  sum_data_q  <= sum_d;
                  sum_ch_q    <= win_id;
                  ptr_q       <= ptr_d;
               end
            end
            FULL: begin
               if (xfer) begin
                  state_q     <= FULL;
                  sum_valid_q <= 1'b1;
                  sum_data_q  <= sum_d;
                  sum_ch_q    <= win_id;
                  ptr_q       <= ptr_d;
               end else if (sum_ready) begin
                  state_q     <= EMPTY;
                  sum_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= EMPTY;
               sum_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign sum_valid = sum_valid_q;
   assign sum_data  = sum_data_q;
   assign sum_ch    = sum_ch_q;

`ifdef ARB_STATS_EN
   logic [15:0] cnt_q [n_ch];

   // Count each channel's transfers. The counters stick at all-ones and are
   // cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < n_ch; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < n_ch; i++) begin
            if (hs[i] && (cnt_q[i] != 16'hFFFF)) begin
               cnt_q[i] <= cnt_q[i] + 16'd1;
            end
         end
      end
   end

   // Flatten the counter array onto the packed statistics port.
   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < n_ch; i++) begin
         grant_cnt[i*16 +: 16] = cnt_q[i];
      end
   end
`endif

endmodule
